// File: rtl/model_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// model_ram_loader_pkg
// Shared types and constants for the triangle model RAM. The writer
// (model_ram_loader) and the projection-stage reader both use these.
//   loader_state_t : loader FSM states
//   err_code_t     : abort reason reported on err_code
//   TRI_W          : width of one packed triangle word
//   V*_HI/_LO      : vertex coordinate fields inside a triangle word
//   ATTR_HI/_LO    : per-triangle attribute field
// -----------------------------------------------------------------------------
package model_ram_loader_pkg;

    localparam int TRI_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_COUNT = 2'd1,
        ERR_BAD_CHK   = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_code_t;

    // Nine 6-bit coordinates packed from the top of the word, MSB first.
    localparam int V1X_HI = 63;  localparam int V1X_LO = 58;
    localparam int V1Y_HI = 57;  localparam int V1Y_LO = 52;
    localparam int V1Z_HI = 51;  localparam int V1Z_LO = 46;
    localparam int V2X_HI = 45;  localparam int V2X_LO = 40;
    localparam int V2Y_HI = 39;  localparam int V2Y_LO = 34;
    localparam int V2Z_HI = 33;  localparam int V2Z_LO = 28;
    localparam int V3X_HI = 27;  localparam int V3X_LO = 22;
    localparam int V3Y_HI = 21;  localparam int V3Y_LO = 16;
    localparam int V3Z_HI = 15;  localparam int V3Z_LO = 10;
    localparam int ATTR_HI = 9;  localparam int ATTR_LO = 0;

endpackage

// File: rtl/model_ram_loader_packer.sv
// -----------------------------------------------------------------------------
// model_ram_loader_packer
// Assembles eight consecutive bytes into one triangle word, first byte in the
// most significant position. Emits a one-cycle word_valid pulse the cycle after
// the eighth byte is shifted in; o_word holds the complete word in that cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clear         restart at byte 0 (start of a new frame)
//   i_shift         shift i_byte into the word
//   i_byte          byte to shift in
//   o_word          assembly register
//   o_word_valid    pulse: o_word holds a complete triangle
//   o_byte_idx      position of the next byte within the word (0..7)
// -----------------------------------------------------------------------------
module model_ram_loader_packer
    import model_ram_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic [7:0]       i_byte,
    output logic [TRI_W-1:0] o_word,
    output logic             o_word_valid,
    output logic [2:0]       o_byte_idx
);

    logic [TRI_W-1:0] r_word;
    logic             r_word_valid;
    logic [2:0]       r_byte_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_byte_idx   <= 3'd0;
        end else begin
            r_word_valid <= i_shift && (r_byte_idx == 3'd7);
            if (i_clear) begin
                r_byte_idx <= 3'd0;
            end else if (i_shift) begin
                r_word     <= {r_word[TRI_W-9:0], i_byte};
                // 3-bit index wraps 7 -> 0 on its own at each word boundary
                r_byte_idx <= r_byte_idx + 3'd1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_idx   = r_byte_idx;

endmodule

// File: rtl/model_ram_loader.sv
// -----------------------------------------------------------------------------
// model_ram_loader
// Writer side of the 64-bit triangle model RAM. Parses a framed byte stream
//   SYNC_BYTE, N, N*8 data bytes (MSB first), CHK (XOR of N and all data)
// writes each triangle to the RAM as it completes, and commits tri_count /
// model_valid only when the checksum matches. Bad counts, bad checksums and
// idle timeouts inside a frame abort with an err pulse and a held err_code.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   byte_in/_valid stream byte and its valid
//   byte_ready     always 1 out of reset (no back-pressure)
//   ram_we/addr/din RAM write port, ram_we is a single-cycle pulse
//   busy           frame in progress
//   done / err     one-cycle pulses: frame committed / frame aborted
//   err_code       reason of the most recent abort
//   tri_count      triangles in the last committed frame
//   model_valid    RAM holds a complete, checked model
// -----------------------------------------------------------------------------
module model_ram_loader
    import model_ram_loader_pkg::*;
#(
    parameter int          SIZE      = 4,
    parameter int          ADDRW     = $clog2(SIZE),
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_addr,
    output logic [TRI_W-1:0] ram_din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [ADDRW:0]   tri_count,
    output logic             model_valid
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [ADDRW:0]   TRI_ONE  = (ADDRW + 1)'(1);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic             r_ready;
    logic [7:0]       r_acc;
    logic [ADDRW:0]   r_n;
    logic [ADDRW:0]   r_tri_idx;
    logic [TMO_W-1:0] r_tmo;
    logic [ADDRW-1:0] r_ram_addr;
    logic             r_done;
    logic             r_err;
    err_code_t        r_err_code;
    logic [ADDRW:0]   r_tri_count;
    logic             r_model_valid;

    logic             w_xfer;
    logic             w_is_sync;
    logic             w_bad_count;
    logic             w_last_byte;
    logic             w_last_tri;
    logic             w_chk_ok;
    logic             w_tmo_fire;
    logic             w_ev_done;
    logic             w_ev_err;
    err_code_t        w_ev_code;
    logic             w_shift;
    logic             w_clear;
    logic [2:0]       w_byte_idx;
    logic [TRI_W-1:0] w_word;
    logic             w_word_valid;

    assign w_xfer      = byte_valid && r_ready;
    assign w_is_sync   = (byte_in == SYNC_BYTE);
    assign w_bad_count = (byte_in == 8'd0) || (int'(byte_in) > SIZE);
    assign w_last_byte = (w_byte_idx == 3'd7);
    assign w_last_tri  = ((r_tri_idx + TRI_ONE) == r_n);
    assign w_chk_ok    = (byte_in == r_acc);
    // A transfer in the expiry cycle takes priority over the timeout.
    assign w_tmo_fire  = (r_state != ST_IDLE) && !w_xfer && (r_tmo == TMO_LAST);

    model_ram_loader_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_byte       (byte_in),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_idx   (w_byte_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and frame-level events
    always_comb begin
        w_next    = r_state;
        w_ev_done = 1'b0;
        w_ev_err  = 1'b0;
        w_ev_code = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && w_is_sync) begin
                    w_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_xfer) begin
                    if (w_bad_count) begin
                        w_ev_err  = 1'b1;
                        w_ev_code = ERR_BAD_COUNT;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last_byte && w_last_tri) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    if (w_chk_ok) begin
                        w_ev_done = 1'b1;
                    end else begin
                        w_ev_err  = 1'b1;
                        w_ev_code = ERR_BAD_CHK;
                    end
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_tmo_fire) begin
            w_ev_err  = 1'b1;
            w_ev_code = ERR_TIMEOUT;
            w_next    = ST_IDLE;
        end
    end

    // Datapath strobes
    always_comb begin
        w_shift = (r_state == ST_DATA) && w_xfer;
        w_clear = (r_state == ST_IDLE) && w_xfer && w_is_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready       <= 1'b0;
            r_acc         <= 8'd0;
            r_n           <= '0;
            r_tri_idx     <= '0;
            r_tmo         <= '0;
            r_ram_addr    <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_tri_count   <= '0;
            r_model_valid <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_done  <= w_ev_done;
            r_err   <= w_ev_err;
            if (w_ev_err) begin
                r_err_code <= w_ev_code;
            end

            // Idle counter only runs inside a frame; any transfer restarts it.
            if ((r_state == ST_IDLE) || w_xfer || w_tmo_fire) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_ONE;
            end

            if (w_clear) begin
                r_acc     <= 8'd0;
                r_tri_idx <= '0;
            end

            if ((r_state == ST_COUNT) && w_xfer && !w_bad_count) begin
                r_n           <= byte_in[ADDRW:0];
                r_acc         <= byte_in;
                // RAM is about to be overwritten; the old model is gone.
                r_model_valid <= 1'b0;
            end

            if (w_shift) begin
                r_acc <= r_acc ^ byte_in;
                if (w_last_byte) begin
                    // Address is captured alongside the packer's word_valid pulse.
                    r_ram_addr <= r_tri_idx[ADDRW-1:0];
                    r_tri_idx  <= r_tri_idx + TRI_ONE;
                end
            end

            if (w_ev_done) begin
                r_tri_count   <= r_n;
                r_model_valid <= 1'b1;
            end
        end
    end

    assign byte_ready  = r_ready;
    assign ram_we      = w_word_valid;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = w_word;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign tri_count   = r_tri_count;
    assign model_valid = r_model_valid;

endmodule
